// File: rtl/latch.sv
// Clock-synchronous gated D latch with change pulse and saturating change counter.
// Q tracks D on rising clk edges while E is high and holds while E is low; Qb is ~Q.
// Optional build macro LATCH_TRANSPARENT_EN: Q/Qb bypass the register while E is
// high (zero latency). Without it, Q/Qb come straight from the register.
module latch #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic             E,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qb,
   output logic             chg,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] stored;
   logic             capture_new;

   // A capture only counts as a change when the gate is open and D differs from
   // what is held; with E low, D is never examined so unknowns on D stay out.
   always_comb begin
      capture_new = 1'b0;
      if (E && (D != stored)) begin
         capture_new = 1'b1;
      end
   end

   // Storage register, change pulse and saturating change counter; reset wins over E.
   always_ff @(posedge clk) begin
      if (rst) begin
         stored  <= RESET_VAL;
         chg     <= 1'b0;
         chg_cnt <= '0;
      end else begin
         chg <= 1'b0;
         if (capture_new) begin
            stored <= D;
            chg    <= 1'b1;
            if (chg_cnt != CNT_MAX) begin
               chg_cnt <= chg_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef LATCH_TRANSPARENT_EN
   // Open gate passes D straight through; Qb shares the same path so it is always ~Q.
   always_comb begin
      Q = stored;
      if (E && !rst) begin
         Q = D;
      end
      Qb = ~Q;
   end
`else
   // Outputs taken directly from the single storage register (glitch-free).
   always_comb begin
      Q  = stored;
      Qb = ~stored;
   end
`endif

endmodule

// File: tb/tb_latch.sv
// Self-checking bench for latch: two instances (1-bit default config, and a
// 4-bit instance with non-zero reset value and a 2-bit counter) driven from
// shared stimulus and compared against a behavioural model.
module tb_latch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       E   = 1'b0;
   logic [3:0] d_b = 4'h0;
   logic       d_a;

   logic       q_a, qb_a, chg_a;
   logic [7:0] cnt_a;
   logic [3:0] q_b, qb_b;
   logic       chg_b;
   logic [1:0] cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [3:0] ma_q, mb_q;
   int         ma_cnt, mb_cnt;
   logic       ma_chg, mb_chg;

   localparam logic [3:0] RV_B = 4'hA;

   assign d_a = d_b[0];

   always #5 clk = ~clk;

   latch u_dut_a (
      .clk(clk), .rst(rst), .D(d_a), .E(E),
      .Q(q_a), .Qb(qb_a), .chg(chg_a), .chg_cnt(cnt_a)
   );

   latch #(.WIDTH(4), .RESET_VAL(4'hA), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .D(d_b), .E(E),
      .Q(q_b), .Qb(qb_b), .chg(chg_b), .chg_cnt(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected visible Q given the stored value and the inputs currently applied.
   function automatic logic [3:0] vis_q(input logic [3:0] held, input logic r,
                                        input logic e, input logic [3:0] d);
`ifdef LATCH_TRANSPARENT_EN
      return (e && !r) ? d : held;
`else
      return held;
`endif
   endfunction

   task automatic check_outputs(input string ph, input logic r, input logic e,
                                input logic [3:0] d);
      logic [3:0] ea, eb;
      ea = vis_q(ma_q, r, e, {3'b0, d[0]});
      eb = vis_q(mb_q, r, e, d);
      check({ph, "_q_a"},  {31'b0, q_a},  {31'b0, ea[0]});
      check({ph, "_qb_a"}, {31'b0, qb_a}, {31'b0, ~ea[0]});
      check({ph, "_q_b"},  {28'b0, q_b},  {28'b0, eb});
      check({ph, "_qb_b"}, {28'b0, qb_b}, {28'b0, ~eb});
   endtask

   // Apply one cycle of stimulus: drive at negedge, check combinational view,
   // then update the model at the rising edge and check registered outputs.
   task automatic tick(input logic r, input logic e, input logic [3:0] d);
      @(negedge clk);
      rst = r;
      E   = e;
      d_b = d;
      #1;
      check_outputs("pre", r, e, d);
      @(posedge clk);
      #1;
      if (r) begin
         ma_q = 4'h0; ma_cnt = 0; ma_chg = 1'b0;
         mb_q = RV_B; mb_cnt = 0; mb_chg = 1'b0;
      end else begin
         ma_chg = 1'b0;
         mb_chg = 1'b0;
         if (e && (d[0] != ma_q[0])) begin
            ma_q   = {3'b0, d[0]};
            ma_chg = 1'b1;
            ma_cnt = (ma_cnt + 1 > 255) ? 255 : ma_cnt + 1;
         end
         if (e && (d != mb_q)) begin
            mb_q   = d;
            mb_chg = 1'b1;
            mb_cnt = (mb_cnt + 1 > 3) ? 3 : mb_cnt + 1;
         end
      end
      check_outputs("post", r, e, d);
      check("chg_a", {31'b0, chg_a}, {31'b0, ma_chg});
      check("cnt_a", {24'b0, cnt_a}, ma_cnt);
      check("chg_b", {31'b0, chg_b}, {31'b0, mb_chg});
      check("cnt_b", {30'b0, cnt_b}, mb_cnt);
   endtask

   initial begin
      ma_q = 4'h0; mb_q = RV_B; ma_cnt = 0; mb_cnt = 0; ma_chg = 1'b0; mb_chg = 1'b0;

      // reset for 2 cycles
      tick(1'b1, 1'b0, 4'h0);
      tick(1'b1, 1'b0, 4'h0);
      check("rst_q_a", {31'b0, q_a}, 32'd0);
      check("rst_qb_a", {31'b0, qb_a}, 32'd1);
      check("rst_q_b", {28'b0, q_b}, 32'hA);

      // hold with D=1
      repeat (3) tick(1'b0, 1'b0, 4'h1);
      check("hold_q_a", {31'b0, q_a}, 32'd0);

      // capture 0 (no change), capture 1 (change)
      tick(1'b0, 1'b1, 4'h0);
      check("cap0_chg_a", {31'b0, chg_a}, 32'd0);
      tick(1'b0, 1'b1, 4'h1);
      check("cap1_chg_a", {31'b0, chg_a}, 32'd1);
      check("cap1_cnt_a", {24'b0, cnt_a}, 32'd1);

      // E falls, D changes: value retained
      repeat (4) tick(1'b0, 1'b0, 4'h0);
      check("ret_q_a", {31'b0, q_a}, 32'd1);

      // reset priority over E
      tick(1'b0, 1'b1, 4'h1);
      tick(1'b1, 1'b1, 4'h1);
      check("rprio_q_a", {31'b0, q_a}, 32'd0);
      check("rprio_cnt_a", {24'b0, cnt_a}, 32'd0);

      // unknown D during hold must not reach Q
      tick(1'b0, 1'b1, 4'h6);
      repeat (3) tick(1'b0, 1'b0, 4'bxxxx);
      check("xhold_q_b", {28'b0, q_b}, 32'h6);

      // saturation: toggle D with E=1 for 6 cycles after reset
      tick(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, (i % 2 == 1) ? 4'hF : 4'h0);
      check("sat_cnt_b", {30'b0, cnt_b}, 32'd3);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
